// File: rtl/apb_pkg.sv
// APB requester shared definitions: bus widths and the FSM state encoding.
package apb_pkg;

    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_slave_decode.sv
// Slave decode: turns a slave index into the one-hot PSEL mask and muxes the
// selected slave's PRDATA/PREADY. Purely combinational.
module apb_slave_decode
    import apb_pkg::*;
#(
    parameter  int unsigned SLV_BITS   = 2,
    localparam int unsigned NUM_SLAVES = 2 ** SLV_BITS
) (
    input  logic [SLV_BITS-1:0]              idx,
    input  logic [APB_DATA_W*NUM_SLAVES-1:0] prdata_bus,
    input  logic [NUM_SLAVES-1:0]            pready_bus,
    output logic [NUM_SLAVES-1:0]            sel_mask,
    output logic [APB_DATA_W-1:0]            prdata,
    output logic                             pready
);

    // Select mask plus read-data/ready mux of the indexed slave; other slaves are ignored.
    always_comb begin
        sel_mask = '0;
        prdata   = '0;
        pready   = 1'b0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (idx == SLV_BITS'(k)) begin
                sel_mask[k] = 1'b1;
                prdata      = prdata_bus[k*APB_DATA_W +: APB_DATA_W];
                pready      = pready_bus[k];
            end
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB requester: accepts one CPU request at a time, runs IDLE->SETUP->ACCESS
// towards the slave picked by req_addr[SEL_LSB +: SLV_BITS], and returns a
// one-cycle response strobe.
// Optional feature macro: APB_TIMEOUT_EN (ACCESS wait-state timeout with
// rsp_err abort); without it rsp_err is tied low and ACCESS waits forever.
module apb_master
    import apb_pkg::*;
#(
    parameter  int unsigned SLV_BITS    = 2,
    parameter  int unsigned SEL_LSB     = 8,
    parameter  int unsigned TIMEOUT_CYC = 16,
    localparam int unsigned NUM_SLAVES  = 2 ** SLV_BITS
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [APB_ADDR_W-1:0]            req_addr,
    input  logic [APB_DATA_W-1:0]            req_wdata,
    output logic                             rsp_valid,
    output logic [APB_DATA_W-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             READ_WRITE,
    output logic [APB_ADDR_W-1:0]            PADDR,
    output logic [APB_DATA_W-1:0]            PWDATA,
    input  logic [APB_DATA_W*NUM_SLAVES-1:0] PRDATA_BUS,
    input  logic [NUM_SLAVES-1:0]            PREADY_BUS
);

    apb_state_e              state;
    apb_state_e              state_nx;
    logic [SLV_BITS-1:0]     idx_q;
    logic [NUM_SLAVES-1:0]   sel_mask;
    logic [APB_DATA_W-1:0]   sel_prdata;
    logic                    sel_pready;
    logic                    accept;
    logic                    done;
    logic                    abort;
    logic                    timeout_hit;

    apb_slave_decode #(
        .SLV_BITS (SLV_BITS)
    ) u_decode (
        .idx        (idx_q),
        .prdata_bus (PRDATA_BUS),
        .pready_bus (PREADY_BUS),
        .sel_mask   (sel_mask),
        .prdata     (sel_prdata),
        .pready     (sel_pready)
    );

    assign accept = (state == ST_IDLE) && req_valid;

`ifdef APB_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Wait-state counter: cleared on the SETUP->ACCESS step, counts PREADY-low ACCESS cycles.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ST_ACCESS) && !sel_pready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign timeout_hit = (wait_cnt == 8'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register; async reset drops PSEL/PENABLE immediately since both decode from state.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and phase outputs; PREADY on the would-be abort cycle takes precedence.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        PSEL      = '0;
        PENABLE   = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = !PRESET;
                if (req_valid) begin
                    state_nx = ST_SETUP;
                end
            end
            ST_SETUP: begin
                PSEL     = sel_mask;
                state_nx = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = sel_mask;
                PENABLE = 1'b1;
                if (sel_pready) begin
                    done     = 1'b1;
                    state_nx = ST_IDLE;
                end else if (timeout_hit) begin
                    abort    = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Request capture on accept; these drive the APB address/data and hold until the next accept.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            idx_q      <= '0;
            READ_WRITE <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
        end else if (accept) begin
            idx_q      <= req_addr[SEL_LSB +: SLV_BITS];
            READ_WRITE <= req_write;
            PADDR      <= APB_ADDR_W'(req_addr[SEL_LSB-1:0]);
            PWDATA     <= req_write ? req_wdata : '0;
        end
    end

    // Response registers: one-cycle strobe; read data only for completed reads.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= done || abort;
            if (done) begin
                rsp_rdata <= READ_WRITE ? '0 : sel_prdata;
            end else if (abort) begin
                rsp_rdata <= '0;
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    // Error flag accompanies each response: set only for a timeout abort.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_err <= 1'b0;
        end else if (done || abort) begin
            rsp_err <= abort;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule
